// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with per-frame shadowing of the display
// data, PWM brightness, leading-zero blanking and a dead cycle at the end of each slot.

module seg_dec (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end
endmodule

module seg_scan_ctrl #(
  parameter int CLK_FREQ = 200_000_000,
  parameter int SCAN_HZ  = 1000
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic [3:0]  duty,
  output logic [3:0]  seg_sel,
  output logic [7:0]  seg_led,
  output logic        frame_tick
);
  localparam int SLOT_CYC = CLK_FREQ / SCAN_HZ;
  localparam int PH_DIV   = SLOT_CYC / 16;
  localparam int SW       = (PH_DIV > 1) ? $clog2(PH_DIV) : 1;
  localparam int NUM_DIG  = 4;

  if (SLOT_CYC < 16 || (SLOT_CYC % 16) != 0) begin : g_bad_cfg
    $error("seg_scan_ctrl: SLOT_CYC must be >= 16 and a multiple of 16");
  end

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        blank_lz;
    logic [3:0]  duty;
  } frame_t;

  // slot_cnt is kept split as {phase, sub_cnt}: slot_cnt = phase*PH_DIV + sub_cnt,
  // which gives the PWM phase directly without a divider.
  logic [SW-1:0] sub_cnt;
  logic [3:0]    phase;
  logic [1:0]    dig_idx;
  logic          sub_end, slot_end, frame_end;
  frame_t        sh;

  assign sub_end   = (sub_cnt == SW'(PH_DIV - 1));
  assign slot_end  = sub_end && (phase == 4'hF);
  assign frame_end = slot_end && (dig_idx == 2'd3);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sub_cnt <= '0;
      phase   <= '0;
      dig_idx <= '0;
    end else begin
      sub_cnt <= sub_end ? '0 : sub_cnt + 1'b1;
      if (sub_end)  phase   <= phase + 1'b1;
      if (slot_end) dig_idx <= dig_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sh         <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (frame_end) sh <= '{digits: digits, dp: dp_in, blank_lz: blank_lz, duty: duty};
    end
  end

  // Digit g (0 = most significant) shows nibble digits[15-4g -: 4] and dp bit 3-g.
  logic [NUM_DIG-1:0][6:0] dec_seg;
  logic [NUM_DIG-1:0]      blank;
  logic [NUM_DIG-1:0][7:0] dig_led;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    seg_dec u_dec (
      .nib (sh.digits[15-4*g -: 4]),
      .seg (dec_seg[g])
    );
    if (g == NUM_DIG - 1) begin : g_last
      assign blank[g] = 1'b0;
    end else begin : g_lz
      assign blank[g] = sh.blank_lz && (sh.digits[15 -: 4*(g+1)] == '0);
    end
    assign dig_led[g] = {sh.dp[NUM_DIG-1-g], blank[g] ? 7'h00 : dec_seg[g]};
  end

  logic lit;
  assign lit = en && !slot_end && (phase <= sh.duty);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      seg_sel <= '0;
      seg_led <= '0;
    end else if (lit) begin
      seg_sel <= 4'b0001 << dig_idx;
      seg_led <= dig_led[dig_idx];
    end else begin
      seg_sel <= '0;
      seg_led <= '0;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl with SLOT_CYC = 16; expected outputs come from
// a cycle-count model of the scan rather than from the design's registers.

module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        arst, en, blank_lz;
  logic [15:0] digits;
  logic [3:0]  dp_in, duty;
  logic [3:0]  seg_sel;
  logic [7:0]  seg_led;
  logic        frame_tick;

  seg_scan_ctrl #(.CLK_FREQ(1600), .SCAN_HZ(100)) dut (
    .clk        (clk),
    .arst       (arst),
    .en         (en),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .duty       (duty),
    .seg_sel    (seg_sel),
    .seg_led    (seg_led),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
  endtask

  // Model: k = clock edges since reset release; shadow copy of the frame data.
  int          k;
  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_duty;
  logic        m_blz;
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic step();
    int          slot, d;
    logic        lit, e_tick;
    logic [15:0] upper;
    logic [3:0]  e_sel;
    logic [7:0]  e_led;
    slot   = k % 16;
    d      = (k / 16) % 4;
    lit    = en && (slot != 15) && (slot <= int'(m_duty));
    upper  = m_dig >> (12 - 4 * d);
    e_sel  = lit ? 4'(1 << d) : 4'h0;
    e_led  = lit ? {m_dp[3-d], (m_blz && d != 3 && upper == 16'h0) ? 7'h00 : seg_tab[upper[3:0]]}
                 : 8'h00;
    e_tick = (k % 64 == 63);
    if (e_tick) begin
      m_dig  = digits;
      m_dp   = dp_in;
      m_blz  = blank_lz;
      m_duty = duty;
    end
    @(posedge clk);
    k++;
    #1;
    chk("seg_sel", 16'(seg_sel), 16'(e_sel));
    chk("seg_led", 16'(seg_led), 16'(e_led));
    chk("frame_tick", 16'(frame_tick), 16'(e_tick));
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #1;
    chk("rst_sel", 16'(seg_sel), 16'h0);
    chk("rst_led", 16'(seg_led), 16'h0);
    chk("rst_tick", 16'(frame_tick), 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_sel", 16'(seg_sel), 16'h0);
    @(negedge clk);
    arst   = 1'b0;
    k      = 0;
    m_dig  = '0;
    m_dp   = '0;
    m_blz  = 1'b0;
    m_duty = '0;
  endtask

  initial begin
    arst = 1'b0; en = 1'b0; digits = '0; dp_in = '0; blank_lz = 1'b0; duty = '0;
    #2;
    do_reset();

    // steady scan; first frame still shows the reset shadow
    en = 1'b1; digits = 16'h12AF; dp_in = 4'h0; blank_lz = 1'b0; duty = 4'd15;
    repeat (192) step();
    duty = 4'd3;
    repeat (128) step();
    // leading-zero blanking with a dp on the blanked top digit
    digits = 16'h0050; dp_in = 4'b1000; blank_lz = 1'b1; duty = 4'd15;
    repeat (128) step();
    // mid-frame data change must not appear before the next frame
    repeat (20) step();
    digits = 16'hBEEF; blank_lz = 1'b0; dp_in = 4'b0101;
    repeat (100) step();
    en = 1'b0;
    repeat (10) step();
    en = 1'b1;
    repeat (60) step();
    // reset while digit 2 is being scanned
    while (k % 64 != 37) step();
    do_reset();
    repeat (130) step();

    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) digits   = 16'($urandom);
      if ($urandom_range(0, 15) == 0) digits   = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) dp_in    = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 31) == 0) duty     = 4'($urandom);
      if ($urandom_range(0, 19) == 0) en       = ~en;
      if ($urandom_range(0, 999) == 0) do_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
